// File: rtl/mem_stage_sram.sv
// Memory-access pipeline stage: multi-cycle data SRAM with upstream stall
// (freeze) generation and bubble insertion toward the MEM/WB register.
module mem_stage_sram #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_en_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] ST_val_in,
  input  logic [3:0]  Dest_in,
  output logic        freeze,
  output logic        WB_en_out,
  output logic        MEM_R_EN_out,
  output logic [31:0] ALU_result_out,
  output logic [31:0] mem_rdata,
  output logic [3:0]  Dest_out,
  output logic        addr_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);
  localparam logic [32:0]   ADDR_LO  = 33'(BASE_ADDR);
  localparam logic [32:0]   ADDR_HI  = 33'(BASE_ADDR) + 33'(4 * DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [31:0]    mem_q [DEPTH];

  logic           req_c;
  logic           rd_c;
  logic           wr_c;
  logic           in_range_c;
  logic [31:0]    offset_c;
  logic [AW-1:0]  idx_c;
  logic           commit_c;
  logic           mem_we_c;
  logic           freeze_c;
  logic           unused_offset_bits;

  // Request decode; a simultaneous read and write is treated as a read.
  assign req_c      = MEM_R_EN_in | MEM_W_EN_in;
  assign rd_c       = MEM_R_EN_in;
  assign wr_c       = MEM_W_EN_in & ~MEM_R_EN_in;
  assign offset_c   = ALU_result_in - 32'(BASE_ADDR);
  assign idx_c      = offset_c[AW+1:2];
  assign in_range_c = ({1'b0, ALU_result_in} >= ADDR_LO) &&
                      ({1'b0, ALU_result_in} <  ADDR_HI);
  assign unused_offset_bits = ^{offset_c[31:AW+2], offset_c[1:0]};

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_c) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: stall while an access is pending, bubble the MEM/WB controls.
  always_comb begin
    freeze_c = 1'b0;
    case (state_q)
      S_IDLE:  freeze_c = req_c;
      S_BUSY:  freeze_c = 1'b1;
      default: freeze_c = 1'b0;
    endcase
    freeze       = freeze_c;
    WB_en_out    = WB_en_in & ~freeze_c;
    MEM_R_EN_out = MEM_R_EN_in & ~freeze_c;
  end

  assign ALU_result_out = ALU_result_in;
  assign Dest_out       = Dest_in;
  assign mem_rdata      = rdata_q;
  assign addr_err       = err_q;

  // Latency counter and access commit; inputs are held stable by freeze.
  always_comb begin
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we_c = 1'b0;
    commit_c = (state_q == S_BUSY) && (cnt_q == '0);
    if ((state_q == S_IDLE) && req_c) begin
      cnt_d = CNT_INIT;
    end else if ((state_q == S_BUSY) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (commit_c && req_c) begin
      if (!in_range_c) begin
        err_d   = 1'b1;
        rdata_d = '0;
      end else if (rd_c) begin
        rdata_d = mem_q[idx_c];
      end else if (wr_c) begin
        mem_we_c = 1'b1;
      end
    end
  end

  // Datapath registers; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Data array; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[idx_c] <= ST_val_in;
    end
  end

endmodule
